ws2812_decoder: RTL and testbench
=================================

# ws2812_decoder

- Receives the single-wire WS2812 serial stream that the LED driver emits on the matrix data pin.
- Recovers 24-bit GRB pixel words, tags each with its position in the frame, and reports frame boundaries and protocol violations.
- Closes the loop on the 8x8 LED path:
  - in loopback benches, it checks the driver output against the expected green/red/blue arrays;
  - on hardware, a looped-back pin feeds it for self-check.

## Interface
Parameters:
- NUM_PIXELS, 64, pixels per frame; pixel_index width is $clog2(NUM_PIXELS)
- MIN_HIGH, 2, shortest legal high pulse, in clk cycles
- THRESH, 6, high pulses of THRESH clk cycles or more decode as 1; shorter legal pulses decode as 0
- MAX_HIGH, 14, longest legal high pulse, in clk cycles
- RESET_CYCLES, 600, consecutive low cycles that end a frame (50 us at 12 MHz)

Ports:
- clk  in  1  system clock, 12 MHz
- reset  in  1  synchronous, active-high reset
- din  in  1  asynchronous WS2812 serial input
- pixel_valid  out  1  one-cycle strobe; pixel_data and pixel_index are valid in that cycle
- pixel_data  out  24  decoded word {G[7:0],R[7:0],B[7:0]}; first received bit lands in bit 23
- pixel_index  out  $clog2(NUM_PIXELS)  pixel position in the frame, 0-based
- frame_done  out  1  one-cycle strobe at each latch (reset) period that ends a frame
- frame_pixels  out  $clog2(NUM_PIXELS)+1  number of pixels accepted in the frame; valid with frame_done
- overrun  out  1  valid with frame_done; set when more than NUM_PIXELS pixels arrived
- error  out  1  one-cycle strobe on any protocol violation

## Operation
- **Input synchronizer.** din passes through a 2-flop synchronizer to give din_s. All decoding uses din_s.
- **States:**
  - RESET_WAIT: entered from reset and after any error. Counts consecutive din_s=0 cycles and ignores everything else. When the count reaches RESET_CYCLES, go to IDLE with no frame_done.
  - IDLE: frame boundary is established. The first din_s=1 moves to HIGH with high_cnt=1.
  - HIGH: high_cnt increments on each din_s=1 cycle and saturates at MAX_HIGH+1.
    - If high_cnt exceeds MAX_HIGH: error, discard the partial pixel, clear counters, go to RESET_WAIT.
    - On the first din_s=0, classify the pulse:
      - high_cnt < MIN_HIGH: error, go to RESET_WAIT.
      - high_cnt < THRESH: bit 0.
      - otherwise: bit 1.
    - A valid bit shifts into the shift register MSB-first, bit_cnt increments, and the state goes to LOW with low_cnt=1.
  - LOW: low_cnt increments on each din_s=0 cycle.
    - din_s=1 moves to HIGH (high_cnt=1).
    - When low_cnt reaches RESET_CYCLES: frame end, then go to IDLE.
- **Pixel completion.** On the 24th bit:
  - If pix_cnt < NUM_PIXELS: pixel_valid=1, pixel_data=shift word, pixel_index=pix_cnt, then pix_cnt increments.
  - Otherwise: no strobe, and the overrun flag is set.
  - bit_cnt returns to 0 in both cases.
- **Frame end.**
  - Outputs: frame_done=1, frame_pixels=pix_cnt, overrun=flag.
  - If bit_cnt≠0, error pulses in the same cycle and the partial bits are discarded.
  - pix_cnt, bit_cnt and the overrun flag clear.
- Sustained low in IDLE produces no further frame_done.
- **Output hold.** pixel_data, pixel_index, frame_pixels and overrun hold their last values between strobes.

## Timing
- **Reset values:** all outputs 0, state RESET_WAIT, all counters 0.
- **Reset mid-operation:** the partial pixel and frame are discarded with no strobes. After reset the block needs RESET_CYCLES of low before it accepts any data.
- **Pixel latency:** pixel_valid asserts 3 clk edges after the first edge that samples din low at the end of bit 24. That is 2 edges of synchronizer plus 1 registered output.
- **Frame latency:** frame_done asserts on the edge after din_s has been low for RESET_CYCLES consecutive samples.
- **Strobe separation:** strobes are single-cycle. pixel_valid and frame_done never coincide; a pixel completes at least RESET_CYCLES cycles before its frame ends.
- **Pulse-width boundaries, inclusive:**
  - high of MIN_HIGH-1 cycles: error
  - MIN_HIGH to THRESH-1: bit 0
  - THRESH to MAX_HIGH: bit 1
  - MAX_HIGH+1 or more: error, raised in the cycle high_cnt passes MAX_HIGH rather than at the falling edge
- **Low-time rule:** no minimum low time between bits. Any low of 1 to RESET_CYCLES-1 cycles is inter-bit gap.

## Test plan
- **Single pixel.** Reset, 600 low, then 24 bits of 24'hA53C0F using bit 0 = 4 high/11 low and bit 1 = 8 high/7 low, then 600 low.
  -> One pixel_valid with pixel_data=24'hA53C0F and pixel_index=0, then frame_done with frame_pixels=1, overrun=0, no error.
- **Full and overrun frames.**
  - 64 pixels with pixel i = {8'(i),8'(~i),8'(i^8'h55)}: 64 strobes, index 0..63, data matching; frame_done with frame_pixels=64, overrun=0.
  - Repeat with 65 pixels: 64 strobes, frame_done with frame_pixels=64, overrun=1.
- **Thresholds.** Highs of 2, 5, 6 and 14 cycles decode to 0, 0, 1, 1.
  - A 1-cycle high gives an error strobe.
  - A 15-cycle high gives an error on the 15th high sample.
  - After either error, the following 24 bits produce no pixel_valid until 600 low cycles pass.
- **Partial pixel.** 10 bits, then 600 low.
  -> error and frame_done in the same cycle, frame_pixels=0, no pixel_valid.
- **Reset mid-pixel.** After 12 bits, assert reset for 1 cycle, then immediately send 24 bits.
  -> No strobes. A subsequent 600 low plus 24 bits decodes normally at index 0.
- **Latency.** Measure from the din falling edge of bit 24 to pixel_valid.
  -> Exactly 3 clk edges.

Source files
------------

// File: rtl/ws2812_decoder.sv
// ws2812_decoder: recovers 24-bit GRB pixels, frame boundaries and protocol errors from a WS2812 stream
// Ports: clk/reset (sync, active-high); din async serial input;
//   pixel_valid/pixel_data/pixel_index one-cycle pixel strobe with GRB word and frame position;
//   frame_done/frame_pixels/overrun one-cycle frame-end strobe with pixel count and overflow flag;
//   error one-cycle strobe on any pulse-width or partial-pixel violation.
module ws2812_decoder #(
   parameter int NUM_PIXELS   = 64,
   parameter int MIN_HIGH     = 2,
   parameter int THRESH       = 6,
   parameter int MAX_HIGH     = 14,
   parameter int RESET_CYCLES = 600
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          din,
   output logic                          pixel_valid,
   output logic [23:0]                   pixel_data,
   output logic [$clog2(NUM_PIXELS)-1:0] pixel_index,
   output logic                          frame_done,
   output logic [$clog2(NUM_PIXELS):0]   frame_pixels,
   output logic                          overrun,
   output logic                          error
);
   localparam int IW = $clog2(NUM_PIXELS);
   localparam int PW = IW + 1;
   localparam int HW = $clog2(MAX_HIGH + 2);
   localparam int LW = $clog2(RESET_CYCLES + 1);
   localparam logic [HW-1:0] H_MIN = HW'(MIN_HIGH);
   localparam logic [HW-1:0] H_THR = HW'(THRESH);
   localparam logic [HW-1:0] H_MAX = HW'(MAX_HIGH);
   localparam logic [LW-1:0] L_END = LW'(RESET_CYCLES - 1);
   localparam logic [PW-1:0] P_MAX = PW'(NUM_PIXELS);

   typedef enum logic [1:0] {RESET_WAIT, IDLE, HIGH, LOW} state_t;

   state_t          state_q, state_d;
   logic            din_meta_q, din_s_q;
   logic [HW-1:0]   high_cnt_q, high_cnt_d;
   logic [LW-1:0]   low_cnt_q, low_cnt_d;
   logic [4:0]      bit_cnt_q, bit_cnt_d;
   logic [22:0]     shift_q, shift_d;
   logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
   logic            ovf_q, ovf_d;
   logic            pixel_valid_q, pixel_valid_d;
   logic [23:0]     pixel_data_q, pixel_data_d;
   logic [IW-1:0]   pixel_index_q, pixel_index_d;
   logic            frame_done_q, frame_done_d;
   logic [PW-1:0]   frame_pixels_q, frame_pixels_d;
   logic            overrun_q, overrun_d;
   logic            error_q, error_d;
   logic [23:0]     word;
   logic            bad_pulse;

   // word is the shift register with the bit currently being classified appended
   assign word = {shift_q, high_cnt_q >= H_THR};
   // while high: too long once the next sample would pass MAX_HIGH; at the fall: too short
   assign bad_pulse = din_s_q ? (high_cnt_q >= H_MAX) : (high_cnt_q < H_MIN);

   always_comb begin
      state_d        = state_q;
      high_cnt_d     = high_cnt_q;
      low_cnt_d      = low_cnt_q;
      bit_cnt_d      = bit_cnt_q;
      shift_d        = shift_q;
      pix_cnt_d      = pix_cnt_q;
      ovf_d          = ovf_q;
      pixel_valid_d  = 1'b0;
      pixel_data_d   = pixel_data_q;
      pixel_index_d  = pixel_index_q;
      frame_done_d   = 1'b0;
      frame_pixels_d = frame_pixels_q;
      overrun_d      = overrun_q;
      error_d        = 1'b0;
      case (state_q)
         RESET_WAIT: begin
            low_cnt_d = din_s_q ? '0 : low_cnt_q + 1'b1;
            if (!din_s_q && low_cnt_q == L_END) begin
               state_d   = IDLE;
               low_cnt_d = '0;
            end
         end
         IDLE: if (din_s_q) begin
            state_d    = HIGH;
            high_cnt_d = HW'(1);
         end
         HIGH: if (bad_pulse) begin
            error_d    = 1'b1;
            state_d    = RESET_WAIT;
            high_cnt_d = '0;
            low_cnt_d  = '0;
            bit_cnt_d  = '0;
            pix_cnt_d  = '0;
            ovf_d      = 1'b0;
         end else if (din_s_q) begin
            high_cnt_d = high_cnt_q + 1'b1;
         end else begin
            state_d    = LOW;
            low_cnt_d  = LW'(1);
            high_cnt_d = '0;
            shift_d    = word[22:0];
            bit_cnt_d  = (bit_cnt_q == 5'd23) ? '0 : bit_cnt_q + 1'b1;
            if (bit_cnt_q == 5'd23) begin
               if (pix_cnt_q < P_MAX) begin
                  pixel_valid_d = 1'b1;
                  pixel_data_d  = word;
                  pixel_index_d = pix_cnt_q[IW-1:0];
                  pix_cnt_d     = pix_cnt_q + 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end
         LOW: if (din_s_q) begin
            state_d    = HIGH;
            high_cnt_d = HW'(1);
         end else if (low_cnt_q == L_END) begin
            state_d        = IDLE;
            frame_done_d   = 1'b1;
            frame_pixels_d = pix_cnt_q;
            overrun_d      = ovf_q;
            error_d        = |bit_cnt_q;
            low_cnt_d      = '0;
            bit_cnt_d      = '0;
            pix_cnt_d      = '0;
            ovf_d          = 1'b0;
         end else begin
            low_cnt_d = low_cnt_q + 1'b1;
         end
         default: state_d = RESET_WAIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= RESET_WAIT;
         din_meta_q     <= 1'b0;
         din_s_q        <= 1'b0;
         high_cnt_q     <= '0;
         low_cnt_q      <= '0;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         pix_cnt_q      <= '0;
         ovf_q          <= 1'b0;
         pixel_valid_q  <= 1'b0;
         pixel_data_q   <= '0;
         pixel_index_q  <= '0;
         frame_done_q   <= 1'b0;
         frame_pixels_q <= '0;
         overrun_q      <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         din_meta_q     <= din;
         din_s_q        <= din_meta_q;
         high_cnt_q     <= high_cnt_d;
         low_cnt_q      <= low_cnt_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_q        <= shift_d;
         pix_cnt_q      <= pix_cnt_d;
         ovf_q          <= ovf_d;
         pixel_valid_q  <= pixel_valid_d;
         pixel_data_q   <= pixel_data_d;
         pixel_index_q  <= pixel_index_d;
         frame_done_q   <= frame_done_d;
         frame_pixels_q <= frame_pixels_d;
         overrun_q      <= overrun_d;
         error_q        <= error_d;
      end
   end

   assign pixel_valid  = pixel_valid_q;
   assign pixel_data   = pixel_data_q;
   assign pixel_index  = pixel_index_q;
   assign frame_done   = frame_done_q;
   assign frame_pixels = frame_pixels_q;
   assign overrun      = overrun_q;
   assign error        = error_q;
endmodule

// File: tb/tb_ws2812_decoder.sv
// tb_ws2812_decoder: directed stimulus bench for ws2812_decoder
module tb_ws2812_decoder;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        din = 1'b0;
   logic        pixel_valid;
   logic [23:0] pixel_data;
   logic [5:0]  pixel_index;
   logic        frame_done;
   logic [6:0]  frame_pixels;
   logic        overrun;
   logic        error;

   int n_tests = 0;
   int n_fail = 0;
   int err_cnt = 0;
   int e0;
   int lat;
   logic [29:0] pix_q[$];
   logic [8:0]  frm_q[$];

   ws2812_decoder dut (
      .clk(clk), .reset(reset), .din(din),
      .pixel_valid(pixel_valid), .pixel_data(pixel_data), .pixel_index(pixel_index),
      .frame_done(frame_done), .frame_pixels(frame_pixels), .overrun(overrun), .error(error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pixel_valid) pix_q.push_back({pixel_index, pixel_data});
      if (frame_done) frm_q.push_back({error, overrun, frame_pixels});
      if (error) err_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] px(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b, ~b, b ^ 8'h55};
   endfunction

   task automatic hold(input logic v, input int n);
      din = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [23:0] w, input int n);
      for (int i = 23; i > 23 - n; i--) begin
         hold(1'b1, w[i] ? 8 : 4);
         hold(1'b0, w[i] ? 7 : 11);
      end
   endtask

   task automatic clear();
      pix_q.delete();
      frm_q.delete();
   endtask

   task automatic end_frame(input string tag, input int npx, input logic [6:0] fp, input logic ov, input logic er);
      hold(1'b0, 620);
      check({tag, " strobes"}, pix_q.size(), npx);
      check({tag, " frames"}, frm_q.size(), 1);
      if (frm_q.size() > 0) check({tag, " frame err/ovr/pix"}, frm_q[0], {er, ov, fp});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset outputs", {pixel_valid, pixel_data, pixel_index, frame_done, frame_pixels, overrun, error}, 64'd0);
      reset = 1'b0;
      hold(1'b0, 605);
      // single pixel with latency measurement on the final bit
      clear();
      e0 = err_cnt;
      send_bits(24'hA53C0F, 23);
      hold(1'b1, 8);
      din = 1'b0;
      lat = 0;
      for (int k = 0; k < 10 && !pixel_valid; k++) begin
         @(posedge clk);
         lat++;
         #1;
      end
      check("pixel latency", lat, 3);
      end_frame("single", 1, 7'd1, 1'b0, 1'b0);
      if (pix_q.size() > 0) check("single data", pix_q[0], {6'd0, 24'hA53C0F});
      check("single errors", err_cnt - e0, 0);
      check("hold pixel_data", pixel_data, 24'hA53C0F);
      check("hold frame_pixels", frame_pixels, 7'd1);
      // full frame
      clear();
      for (int i = 0; i < 64; i++) send_bits(px(i), 24);
      end_frame("full", 64, 7'd64, 1'b0, 1'b0);
      for (int i = 0; i < pix_q.size(); i++) check($sformatf("full px%0d", i), pix_q[i], {6'(i), px(i)});
      // overrun frame
      clear();
      for (int i = 0; i < 65; i++) send_bits(px(i), 24);
      end_frame("overrun", 64, 7'd64, 1'b1, 1'b0);
      if (pix_q.size() == 64) check("overrun last", pix_q[63], {6'd63, px(63)});
      // pulse-width thresholds 2,5,6,14 -> 0,0,1,1
      clear();
      e0 = err_cnt;
      hold(1'b1, 2);  hold(1'b0, 11);
      hold(1'b1, 5);  hold(1'b0, 11);
      hold(1'b1, 6);  hold(1'b0, 11);
      hold(1'b1, 14); hold(1'b0, 11);
      send_bits({20'h12345, 4'h0}, 20);
      end_frame("thresh", 1, 7'd1, 1'b0, 1'b0);
      if (pix_q.size() > 0) check("thresh data", pix_q[0], {6'd0, 24'h312345});
      check("thresh errors", err_cnt - e0, 0);
      // 1-cycle high
      clear();
      e0 = err_cnt;
      hold(1'b1, 1);
      hold(1'b0, 11);
      send_bits(24'hFFFFFF, 24);
      check("short errors", err_cnt - e0, 1);
      check("short no pixel", pix_q.size(), 0);
      hold(1'b0, 620);
      check("short no frame", frm_q.size(), 0);
      send_bits(24'h00FF00, 24);
      end_frame("after short", 1, 7'd1, 1'b0, 1'b0);
      if (pix_q.size() > 0) check("after short data", pix_q[0], {6'd0, 24'h00FF00});
      // 15-cycle high: error on the 15th high sample, i.e. 17 edges after din rises
      clear();
      e0 = err_cnt;
      din = 1'b1;
      lat = 0;
      for (int k = 0; k < 30 && !error; k++) begin
         @(posedge clk);
         lat++;
         #1;
      end
      check("long err edge", lat, 17);
      hold(1'b0, 11);
      send_bits(24'hFFFFFF, 24);
      check("long errors", err_cnt - e0, 1);
      check("long no pixel", pix_q.size(), 0);
      hold(1'b0, 620);
      check("long no frame", frm_q.size(), 0);
      send_bits(24'h123456, 24);
      end_frame("after long", 1, 7'd1, 1'b0, 1'b0);
      if (pix_q.size() > 0) check("after long data", pix_q[0], {6'd0, 24'h123456});
      // partial pixel
      clear();
      e0 = err_cnt;
      send_bits(24'hABCDEF, 10);
      end_frame("partial", 0, 7'd0, 1'b0, 1'b1);
      check("partial errors", err_cnt - e0, 1);
      // reset mid-pixel
      clear();
      e0 = err_cnt;
      send_bits(24'hFFF000, 12);
      din = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("midreset outputs", {pixel_valid, pixel_data, pixel_index, frame_done, frame_pixels, overrun, error}, 64'd0);
      reset = 1'b0;
      send_bits(24'hC3C3C3, 24);
      check("midreset no pixel", pix_q.size(), 0);
      check("midreset no frame", frm_q.size(), 0);
      check("midreset errors", err_cnt - e0, 0);
      hold(1'b0, 620);
      send_bits(24'h5A5A5A, 24);
      end_frame("post reset", 1, 7'd1, 1'b0, 1'b0);
      if (pix_q.size() > 0) check("post reset data", pix_q[0], {6'd0, 24'h5A5A5A});
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
